// File: rtl/aes_spi_sync.sv
// aes_spi_sync: clk-domain SPI front end that deserialises key/plaintext and serialises cyphertext
module aes_spi_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int BLOCK_W     = 128
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               sck,
  input  logic               sdi,
  input  logic               load,
  output logic               sdo,
  output logic [BLOCK_W-1:0] key,
  output logic [BLOCK_W-1:0] plaintext,
  output logic               start,
  input  logic               core_done,
  input  logic [BLOCK_W-1:0] cyphertext,
  output logic               done,
  output logic               frame_err,
  output logic [1:0]         state_dbg
);
  localparam int FRAME = 2 * BLOCK_W;
  localparam int CW    = $clog2(FRAME + 1);

  typedef enum logic [1:0] {IDLE, SHIFT_IN, WAIT_CORE, READY} state_t;

  state_t             state;
  logic [SYNC_STAGES:0]   sck_s, load_s;
  logic [SYNC_STAGES-1:0] sdi_s;
  logic [FRAME-1:0]   shift_in, shift_nxt;
  logic [CW-1:0]      cnt, cnt_nxt;
  logic [BLOCK_W-1:0] out_reg;
  logic               arm;
  logic               sck_rise, sck_fall, load_rise, load_fall, full;

  // pin synchronisers; the top bit of sck/load chains is the edge-detect history
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sck_s  <= '0;
      load_s <= '0;
      sdi_s  <= '0;
    end else begin
      sck_s  <= {sck_s[SYNC_STAGES-1:0], sck};
      load_s <= {load_s[SYNC_STAGES-1:0], load};
      sdi_s  <= {sdi_s[SYNC_STAGES-2:0], sdi};
    end

  assign sck_rise  = sck_s[SYNC_STAGES-1] & ~sck_s[SYNC_STAGES];
  assign sck_fall  = ~sck_s[SYNC_STAGES-1] & sck_s[SYNC_STAGES];
  assign load_rise = load_s[SYNC_STAGES-1] & ~load_s[SYNC_STAGES];
  assign load_fall = ~load_s[SYNC_STAGES-1] & load_s[SYNC_STAGES];
  assign full      = cnt == CW'(FRAME);

  // next shift/count so a bit arriving with the load fall is counted before the frame check
  always_comb begin
    shift_nxt = (sck_rise && !full) ? {shift_in[FRAME-2:0], sdi_s[SYNC_STAGES-1]} : shift_in;
    cnt_nxt   = (sck_rise && !full) ? cnt + CW'(1) : cnt;
  end

  // control FSM; start trails the latch by one clk via arm
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state     <= IDLE;
      shift_in  <= '0;
      cnt       <= '0;
      out_reg   <= '0;
      key       <= '0;
      plaintext <= '0;
      arm       <= 1'b0;
      start     <= 1'b0;
      done      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      start <= arm;
      arm   <= 1'b0;
      case (state)
        IDLE:
          if (load_rise) begin
            cnt       <= '0;
            frame_err <= 1'b0;
            state     <= SHIFT_IN;
          end
        SHIFT_IN: begin
          shift_in <= shift_nxt;
          cnt      <= cnt_nxt;
          if (load_fall) begin
            if (cnt_nxt == CW'(FRAME)) begin
              key       <= shift_nxt[BLOCK_W-1:0];
              plaintext <= shift_nxt[FRAME-1:BLOCK_W];
              arm       <= 1'b1;
              state     <= WAIT_CORE;
            end else begin
              frame_err <= 1'b1;
              state     <= IDLE;
            end
          end
        end
        WAIT_CORE:
          if (load_rise) begin
            cnt   <= '0;
            state <= SHIFT_IN;
          end else if (core_done) begin
            out_reg <= cyphertext;
            done    <= 1'b1;
            state   <= READY;
          end
        READY:
          if (load_rise) begin
            done  <= 1'b0;
            cnt   <= '0;
            state <= SHIFT_IN;
          end else if (sck_fall) out_reg <= {out_reg[BLOCK_W-2:0], 1'b0};
      endcase
    end

  assign sdo       = (state == READY) ? out_reg[BLOCK_W-1] : 1'b0;
  assign state_dbg = state;
endmodule

// File: tb/tb_aes_spi_sync.sv
// tb_aes_spi_sync: randomized and directed bench with a frame-level reference model
module tb_aes_spi_sync;
  logic         clk = 0, reset_n = 0, sck = 0, sdi = 0, load = 0, core_done = 0;
  logic [127:0] cyphertext = '0;
  logic         sdo, start, done, frame_err;
  logic [127:0] key, plaintext;
  logic [1:0]   state_dbg;

  int checks = 0, errors = 0, starts = 0;
  bit fb[$];
  logic [127:0] exp_pt, exp_key, ct;

  aes_spi_sync dut (
    .clk(clk), .reset_n(reset_n), .sck(sck), .sdi(sdi), .load(load), .sdo(sdo),
    .key(key), .plaintext(plaintext), .start(start), .core_done(core_done),
    .cyphertext(cyphertext), .done(done), .frame_err(frame_err), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (start === 1'b1) starts++;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bit(input bit b);
    sdi = b;
    cyc(3);
    sck = 1;
    cyc(5);
    sck = 0;
    cyc(4);
  endtask

  task automatic shift_bits(input int n);
    for (int i = 0; i < n; i++) spi_bit(fb[i]);
  endtask

  task automatic rand_frame(input int n);
    fb.delete();
    for (int i = 0; i < n; i++) fb.push_back(1'($urandom_range(0, 1)));
  endtask

  // frame = plaintext MSB first then key MSB first; only the first 256 bits matter
  task automatic model();
    exp_pt = '0;
    exp_key = '0;
    for (int i = 0; i < 128; i++) exp_pt = {exp_pt[126:0], fb[i]};
    for (int i = 128; i < 256; i++) exp_key = {exp_key[126:0], fb[i]};
  endtask

  task automatic good_frame(input bit raise, input string tag);
    int s0;
    s0 = starts;
    if (raise) begin load = 1; cyc(8); end
    shift_bits(fb.size());
    load = 0;
    cyc(8);
    model();
    chk({tag, "_pt"}, plaintext, exp_pt);
    chk({tag, "_key"}, key, exp_key);
    chk({tag, "_start"}, starts - s0, 1);
    chk({tag, "_state"}, state_dbg, 2);
    chk({tag, "_ferr"}, frame_err, 0);
  endtask

  task automatic readout(input int nfalls, input string tag);
    logic [127:0] sh;
    core_done = 1;
    cyphertext = ct;
    for (int i = 0; i < 20 && done !== 1'b1; i++) cyc(1);
    core_done = 0;
    chk({tag, "_done"}, done, 1);
    chk({tag, "_state"}, state_dbg, 3);
    chk({tag, "_sdo0"}, sdo, ct[127]);
    for (int k = 1; k <= nfalls; k++) begin
      spi_bit(0);
      sh = ct << k;
      chk($sformatf("%s_sdo%0d", tag, k), sdo, sh[127]);
    end
  endtask

  initial begin
    logic [127:0] old_pt, old_key;
    int s0;
    // reset with pins toggling
    for (int i = 0; i < 6; i++) begin sck = ~sck; load = ~load; cyc(3); end
    chk("rst_key", key, 0);
    chk("rst_pt", plaintext, 0);
    chk("rst_flags", {start, done, frame_err, sdo}, 0);
    chk("rst_state", state_dbg, 0);
    sck = 0; load = 0;
    cyc(2);
    reset_n = 1;
    cyc(10);
    chk("post_rst_state", state_dbg, 0);
    chk("post_rst_out", {key, plaintext}, 0);

    // directed good frame and readout
    exp_pt = 128'h00112233445566778899aabbccddeeff;
    exp_key = 128'h000102030405060708090a0b0c0d0e0f;
    fb.delete();
    for (int i = 127; i >= 0; i--) fb.push_back(exp_pt[i]);
    for (int i = 127; i >= 0; i--) fb.push_back(exp_key[i]);
    good_frame(1, "dir");
    ct = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    readout(8, "rd");
    for (int i = 0; i < 120; i++) spi_bit(0);
    chk("rd_drained", sdo, 0);

    // short frame: error, nothing latched
    old_pt = plaintext; old_key = key; s0 = starts;
    rand_frame(255);
    load = 1; cyc(8);
    chk("short_done_clr", done, 0);
    shift_bits(255);
    load = 0; cyc(8);
    chk("short_ferr", frame_err, 1);
    chk("short_start", starts - s0, 0);
    chk("short_keep", {plaintext, key}, {old_pt, old_key});
    chk("short_state", state_dbg, 0);

    // long frame: first 256 bits only
    rand_frame(260);
    good_frame(1, "long");

    // abort in WAIT_CORE, late core_done ignored, then a fresh frame
    load = 1; cyc(8);
    chk("abort_state", state_dbg, 1);
    core_done = 1; cyc(6); core_done = 0;
    chk("abort_done", done, 0);
    rand_frame(256);
    good_frame(0, "abort_new");

    // randomized good frames with random core latency
    for (int n = 0; n < 3; n++) begin
      rand_frame(256);
      good_frame(1, $sformatf("rnd%0d", n));
      ct = {$urandom, $urandom, $urandom, $urandom};
      cyc($urandom_range(1, 10));
      chk($sformatf("rnd%0d_nodone", n), done, 0);
      readout(12, $sformatf("rnd%0d_rd", n));
    end

    // mid-frame reset
    rand_frame(256);
    load = 1; cyc(8);
    shift_bits(100);
    reset_n = 0;
    #1;
    chk("mid_rst_out", {key, plaintext}, 0);
    chk("mid_rst_flags", {state_dbg, start, done, frame_err, sdo}, 0);
    load = 0;
    cyc(3);
    reset_n = 1;
    cyc(5);
    rand_frame(256);
    good_frame(1, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/aes_spi_sync.md
Name: aes_spi_sync

Overview:
- System-clock-domain SPI front end for the AES block. Sits between the MCU pins and aes_core.
- Oversamples the asynchronous sck/sdi/load pins on clk and deserialises a 256-bit frame into key and plaintext.
- Issues a single-cycle start to the core.
- Captures the core's cyphertext on core_done and serialises it back out on sdo.
- Replaces sck-clocked shifting, so all AES datapath state lives in one clock domain.

Parameters:
- SYNC_STAGES, 2: flops in each pin synchroniser chain (minimum 2).
- BLOCK_W, 128: width of key, plaintext and cyphertext. The frame is 2*BLOCK_W bits.

Ports:
- clk  input  1  system clock (HSOSC, 24 MHz).
- reset_n  input  1  asynchronous active-low reset.
- sck  input  1  SPI clock from MCU, asynchronous to clk, mode 0.
- sdi  input  1  SPI data in, MSB first.
- load  input  1  MCU frame strobe, asynchronous. High during shift-in.
- sdo  output  1  SPI data out.
- key  output  BLOCK_W  latched key to the core.
- plaintext  output  BLOCK_W  latched plaintext to the core.
- start  output  1  one-clk pulse telling the core to begin.
- core_done  input  1  core completion flag, level, synchronous to clk.
- cyphertext  input  BLOCK_W  core result, valid while core_done is high.
- done  output  1  result ready for readout (to MCU pin).
- frame_err  output  1  last frame was not exactly 2*BLOCK_W bits.
- state_dbg  output  2  current FSM state encoding.

Behaviour:

Reset (reset_n low, asynchronous):
- Synchronisers, shift registers and bit counter cleared; FSM in IDLE.
- key=0, plaintext=0, start=0, done=0, frame_err=0, sdo=0, state_dbg=0.

Synchronisation and edge detection:
- sck, sdi and load each pass through SYNC_STAGES flops, plus one history flop for edge detection.
- Rise and fall pulses are one clk wide and lag the pin by SYNC_STAGES+1 clk.
- sdi is sampled from its synchronised copy on the synchronised sck rise.
- Requirement: sck high and low times are each at least SYNC_STAGES+2 clk periods.

Frame format: plaintext bits first, MSB first, then key bits, MSB first. A frame is 256 bits at BLOCK_W=128.

FSM encoding: IDLE=0, SHIFT_IN=1, WAIT_CORE=2, READY=3.

IDLE:
- load rise: clear bit counter, clear frame_err, go to SHIFT_IN.

SHIFT_IN:
- Each sck rise: shift_in <= {shift_in[254:0], sdi}; counter increments and saturates at 256.
- sck rises after the counter reaches 256 are ignored. The shift register is frozen.
- load fall with counter==256: on the same clk, key <= shift_in[127:0] and plaintext <= shift_in[255:128]. start pulses 1 clk on the following clk. Go to WAIT_CORE.
- load fall with counter!=256: frame_err <= 1; key, plaintext and start unchanged; go to IDLE.
- sck rise and load fall detected in the same clk: the bit is shifted and counted first, then the load fall is evaluated.

WAIT_CORE:
- core_done high: out_reg <= cyphertext, done <= 1, go to READY.
- load rise before core_done: abort. Clear counter, go to SHIFT_IN. A later core_done is ignored until the next start.

READY:
- sdo = out_reg[BLOCK_W-1] combinationally.
- Each sck fall: out_reg <= {out_reg[126:0], 1'b0}. After 128 falls sdo reads 0.
- load rise: done <= 0, clear counter, go to SHIFT_IN.

Other rules:
- sdo=0 in IDLE, SHIFT_IN and WAIT_CORE.
- key and plaintext hold their values until the next good frame.
- reset_n asserted mid-operation: immediate return to reset values. No partial frame survives.

Test Plan:
1. Reset: hold reset_n low during sck/load toggling -> all outputs 0, state_dbg=0. After release, outputs stay 0 until a load rise.
2. Good frame: shift 00112233445566778899aabbccddeeff then 000102030405060708090a0b0c0d0e0f, then drop load -> plaintext=0011…eeff, key=0001…0e0f, exactly one start pulse, state_dbg=2.
3. Readout: after (2), drive core_done=1 with cyphertext=69c4e0d86a7b0430d8cdb78070b4c55a -> done=1, state_dbg=3, sdo=0 before the first sck fall. Over the first 8 sck falls sdo reads 1,1,0,1,0,0,1,1, i.e. 0x69 with its MSB already on sdo before the first fall.
4. Short and long frames: 255 bits then load fall -> frame_err=1, no start, key/plaintext unchanged. 260 bits -> only the first 256 bits latched, start pulses.
5. Abort: load rise in WAIT_CORE, then core_done -> done stays 0. A new 256-bit frame is accepted normally.
6. Mid-frame reset: assert reset_n low after 100 bits -> immediate reset values. A following full frame latches correctly.
